rx_ctrl_unit: RTL and testbench

//   Receive control FSM for the serial receiver datapath. It drives the clear and count_enable

---
 rtl/rx_ctrl_unit.sv | 120 ++++++++++++
 tb/tb_rx_ctrl_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_ctrl_unit.sv
// Receive control FSM for the serial receiver: sequences the bit-period timer and bit counter,
// checks the stop bit, strobes the buffer load and keeps host-side status flags.
module rx_ctrl_unit #(
    parameter int unsigned NUM_CNT_BITS = 4,
    parameter int unsigned BIT_PERIOD   = 10,
    parameter int unsigned PACKET_BITS  = 9
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    start_bit_detected,
    input  logic                    shift_strobe,
    input  logic                    packet_done,
    input  logic                    stop_bit,
    input  logic                    data_read,
    output logic                    tmr_clear,
    output logic                    tmr_enable,
    output logic [NUM_CNT_BITS-1:0] tmr_rollover_val,
    output logic                    bit_clear,
    output logic                    bit_enable,
    output logic [NUM_CNT_BITS-1:0] bit_rollover_val,
    output logic                    load_buffer,
    output logic                    data_ready,
    output logic                    framing_error,
    output logic                    overrun_error
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        RECEIVE  = 3'd2,
        STOP_CHK = 3'd3,
        LOAD     = 3'd4
    } state_t;

    state_t state;
    state_t next_state;

    assign tmr_rollover_val = NUM_CNT_BITS'(BIT_PERIOD);
    assign bit_rollover_val = NUM_CNT_BITS'(PACKET_BITS);

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and Moore strobes; bit_enable passes the timer rollover through while receiving
    always_comb begin
        next_state  = state;
        tmr_clear   = 1'b0;
        tmr_enable  = 1'b0;
        bit_clear   = 1'b0;
        bit_enable  = 1'b0;
        load_buffer = 1'b0;
        case (state)
            IDLE: begin
                if (start_bit_detected) begin
                    next_state = START;
                end
            end
            START: begin
                tmr_clear  = 1'b1;
                bit_clear  = 1'b1;
                next_state = RECEIVE;
            end
            RECEIVE: begin
                tmr_enable = 1'b1;
                bit_enable = shift_strobe;
                if (packet_done) begin
                    next_state = STOP_CHK;
                end
            end
            STOP_CHK: begin
                next_state = stop_bit ? LOAD : IDLE;
            end
            LOAD: begin
                load_buffer = 1'b1;
                next_state  = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Framing status: cleared when a packet starts, captured at the stop-bit check
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            framing_error <= 1'b0;
        end else if (state == START) begin
            framing_error <= 1'b0;
        end else if (state == STOP_CHK) begin
            framing_error <= ~stop_bit;
        end
    end

    // Host-side buffer status; a load always wins over a concurrent read
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            if (load_buffer) begin
                data_ready <= 1'b1;
            end else if (data_read) begin
                data_ready <= 1'b0;
            end

            if (load_buffer && data_ready && !data_read) begin
                overrun_error <= 1'b1;
            end else if (data_read) begin
                overrun_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rx_ctrl_unit.sv
// Bench for rx_ctrl_unit: timeline model of the receive sequence checked every cycle,
// plus directed packets with hand-computed expectations.
module tb_rx_ctrl_unit;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       start_bit_detected = 1'b0;
    logic       shift_strobe = 1'b0;
    logic       packet_done = 1'b0;
    logic       stop_bit = 1'b1;
    logic       data_read = 1'b0;
    logic       tmr_clear, tmr_enable, bit_clear, bit_enable, load_buffer;
    logic       data_ready, framing_error, overrun_error;
    logic [3:0] tmr_rollover_val, bit_rollover_val;

    rx_ctrl_unit #(.NUM_CNT_BITS(4), .BIT_PERIOD(10), .PACKET_BITS(9)) dut (
        .clk(clk), .n_rst(n_rst),
        .start_bit_detected(start_bit_detected), .shift_strobe(shift_strobe),
        .packet_done(packet_done), .stop_bit(stop_bit), .data_read(data_read),
        .tmr_clear(tmr_clear), .tmr_enable(tmr_enable), .tmr_rollover_val(tmr_rollover_val),
        .bit_clear(bit_clear), .bit_enable(bit_enable), .bit_rollover_val(bit_rollover_val),
        .load_buffer(load_buffer), .data_ready(data_ready),
        .framing_error(framing_error), .overrun_error(overrun_error)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: a packet occupies a window of absolute cycle numbers
    int cyc = 0;
    bit m_busy = 1'b0;
    int t_start = -1;
    int t_chk = -1;
    int t_load = -1;
    bit m_fe = 1'b0, m_dr = 1'b0, m_ov = 1'b0;
    bit was_busy, in_rx, is_load;

    function automatic bit model_rx();
        return m_busy && (cyc > t_start) && (t_chk < 0 || cyc < t_chk);
    endfunction

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_busy = 1'b0;
            m_fe = 1'b0;
            m_dr = 1'b0;
            m_ov = 1'b0;
        end else begin
            was_busy = m_busy;
            in_rx = model_rx();
            is_load = m_busy && (cyc == t_load);
            m_ov = (is_load && m_dr && !data_read) ? 1'b1 : (data_read ? 1'b0 : m_ov);
            m_dr = is_load ? 1'b1 : (data_read ? 1'b0 : m_dr);
            if (m_busy && cyc == t_start) m_fe = 1'b0;
            if (in_rx && packet_done) t_chk = cyc + 1;
            if (m_busy && cyc == t_chk) begin
                m_fe = !stop_bit;
                if (stop_bit) t_load = cyc + 1;
                else m_busy = 1'b0;
            end
            if (is_load) m_busy = 1'b0;
            if (!was_busy && start_bit_detected) begin
                m_busy = 1'b1;
                t_start = cyc + 1;
                t_chk = -1;
                t_load = -1;
            end
            cyc = cyc + 1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("tmr_clear", 32'(tmr_clear), 32'(m_busy && cyc == t_start));
        chk("bit_clear", 32'(bit_clear), 32'(m_busy && cyc == t_start));
        chk("tmr_enable", 32'(tmr_enable), 32'(model_rx()));
        chk("bit_enable", 32'(bit_enable), 32'(model_rx() && shift_strobe));
        chk("load_buffer", 32'(load_buffer), 32'(m_busy && cyc == t_load));
        chk("data_ready", 32'(data_ready), 32'(m_dr));
        chk("framing_error", 32'(framing_error), 32'(m_fe));
        chk("overrun_error", 32'(overrun_error), 32'(m_ov));
        chk("tmr_rollover_val", 32'(tmr_rollover_val), 32'd10);
        chk("bit_rollover_val", 32'(bit_rollover_val), 32'd9);
    end

    int n_tc = 0, n_be = 0, n_lb = 0;
    always @(negedge clk) begin
        if (tmr_clear === 1'b1) n_tc++;
        if (bit_enable === 1'b1) n_be++;
        if (load_buffer === 1'b1) n_lb++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_packet(input bit stop, input bit read_on_load, input bit noisy);
        int tc0 = n_tc;
        int be0 = n_be;
        int lb0 = n_lb;
        step(); start_bit_detected = 1'b1;
        step(); start_bit_detected = 1'b0;
        for (int k = 0; k < 9; k++) begin
            step();
            if (k == 0) chk("fe_cleared_by_start", 32'(framing_error), 32'd0);
            if (noisy && k == 4) start_bit_detected = 1'b1;
            step(); start_bit_detected = 1'b0; shift_strobe = 1'b1;
            step(); shift_strobe = 1'b0;
        end
        packet_done = 1'b1;
        stop_bit = stop;
        if (noisy) start_bit_detected = 1'b1;
        step(); packet_done = 1'b0; start_bit_detected = 1'b0;
        step();
        chk("load_at_pd_plus_2", 32'(load_buffer), 32'(stop));
        data_read = read_on_load;
        step(); data_read = 1'b0;
        chk("tmr_clear_pulses", 32'(n_tc - tc0), 32'd1);
        chk("bit_enable_pulses", 32'(n_be - be0), 32'd9);
        chk("load_pulses", 32'(n_lb - lb0), 32'(stop));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data_ready", 32'(data_ready), 32'd0);
        chk("rst_overrun", 32'(overrun_error), 32'd0);
        chk("rst_tmr_enable", 32'(tmr_enable), 32'd0);
        chk("rst_tmr_roll", 32'(tmr_rollover_val), 32'd10);
        chk("rst_bit_roll", 32'(bit_rollover_val), 32'd9);
        n_rst = 1'b1;
        step(); step();

        // Good packet, not read
        send_packet(1'b1, 1'b0, 1'b0);
        chk("good_dr", 32'(data_ready), 32'd1);
        chk("good_fe", 32'(framing_error), 32'd0);
        chk("good_ov", 32'(overrun_error), 32'd0);

        // Bad stop bit: no load, data_ready untouched
        send_packet(1'b0, 1'b0, 1'b0);
        chk("frm_fe", 32'(framing_error), 32'd1);
        chk("frm_dr", 32'(data_ready), 32'd1);
        chk("frm_ov", 32'(overrun_error), 32'd0);

        // Second good load without a read overruns
        send_packet(1'b1, 1'b0, 1'b0);
        chk("ovr_ov", 32'(overrun_error), 32'd1);
        chk("ovr_dr", 32'(data_ready), 32'd1);
        step(); data_read = 1'b1;
        step(); data_read = 1'b0;
        chk("read_dr", 32'(data_ready), 32'd0);
        chk("read_ov", 32'(overrun_error), 32'd0);

        // Read coincident with load while data_ready is set
        send_packet(1'b1, 1'b0, 1'b0);
        send_packet(1'b1, 1'b1, 1'b0);
        chk("sim_dr", 32'(data_ready), 32'd1);
        chk("sim_ov", 32'(overrun_error), 32'd0);

        // Stray start pulses mid-packet are ignored
        send_packet(1'b1, 1'b1, 1'b1);
        chk("noisy_dr", 32'(data_ready), 32'd1);
        chk("noisy_ov", 32'(overrun_error), 32'd0);

        // Reset in the middle of RECEIVE
        step(); start_bit_detected = 1'b1;
        step(); start_bit_detected = 1'b0;
        step(); step(); shift_strobe = 1'b1;
        #2 n_rst = 1'b0;
        #1;
        chk("mid_rst_bit_enable", 32'(bit_enable), 32'd0);
        chk("mid_rst_tmr_enable", 32'(tmr_enable), 32'd0);
        chk("mid_rst_dr", 32'(data_ready), 32'd0);
        chk("mid_rst_fe", 32'(framing_error), 32'd0);
        shift_strobe = 1'b0;
        @(negedge clk);
        #1 n_rst = 1'b1;
        step(); step();
        chk("post_rst_idle_tmr_enable", 32'(tmr_enable), 32'd0);
        chk("post_rst_idle_tmr_clear", 32'(tmr_clear), 32'd0);

        send_packet(1'b1, 1'b0, 1'b0);
        chk("after_rst_dr", 32'(data_ready), 32'd1);
        chk("after_rst_ov", 32'(overrun_error), 32'd0);
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
